// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module   : mem_arbiter_pkg
// Purpose  : Shared FSM encodings, grant-source constants and width helper
//            for the instruction/data memory arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_arb_select.sv
// ============================================================================
// Module   : arb_select
// Purpose  : Data-priority winner selection with a saturating data-streak
//            counter that hands the slot to a waiting instruction request.
// Revision : 1.0
// ============================================================================
`default_nettype none

module arb_select
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic d_req,
    input  logic grant_en,
    output logic win_d
);

    localparam int SW = cnt_width(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] C_MAX = SW'(MAX_D_STREAK);

    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;

    always_comb begin
        win_d    = d_req && !(i_req && (streak_q == C_MAX));
        streak_d = streak_q;
        if (grant_en) begin
            // Only data grants made while an instruction waits extend the streak.
            if (win_d && i_req) begin
                streak_d = (streak_q == C_MAX) ? streak_q : streak_q + SW'(1);
            end else begin
                streak_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Serialises instruction and data port accesses onto one
//            fixed-latency memory; registered strobes, acks and read data.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WORD_SIZE    = 16,
    parameter int MEM_LATENCY  = 2,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic                 i_we,
    input  logic [WORD_SIZE-1:0] i_addr,
    input  logic [WORD_SIZE-1:0] i_wdata,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_ack,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ack,
    output logic                 m_read,
    output logic                 m_write,
    output logic [WORD_SIZE-1:0] m_addr,
    output logic [WORD_SIZE-1:0] m_wdata,
    input  logic [WORD_SIZE-1:0] m_rdata,
    output logic                 busy,
    output logic                 grant_d
);

    localparam int CW = cnt_width(MEM_LATENCY);
    localparam logic [CW-1:0] C_CNT_LOAD = CW'(MEM_LATENCY - 1);

    logic [1:0]           state_q,   state_d;
    logic [CW-1:0]        cnt_q,     cnt_d;
    logic                 m_read_q,  m_read_d;
    logic                 m_write_q, m_write_d;
    logic [WORD_SIZE-1:0] m_addr_q,  m_addr_d;
    logic [WORD_SIZE-1:0] m_wdata_q, m_wdata_d;
    logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
    logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
    logic                 i_ack_q,   i_ack_d;
    logic                 d_ack_q,   d_ack_d;
    logic                 busy_q,    busy_d;
    logic                 grant_d_q, grant_d_d;

    logic w_grant_en;
    logic w_win_d;
    logic w_we_sel;

    assign w_grant_en = (state_q == ST_IDLE) && (i_req || d_req);
    assign w_we_sel   = w_win_d ? d_we : i_we;

    arb_select #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_arb_select (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .d_req    (d_req),
        .grant_en (w_grant_en),
        .win_d    (w_win_d)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        m_read_d  = m_read_q;
        m_write_d = m_write_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        busy_d    = busy_q;
        grant_d_d = grant_d_q;
        case (state_q)
            ST_IDLE: begin
                if (w_grant_en) begin
                    grant_d_d = w_win_d ? GRANT_D : GRANT_I;
                    m_addr_d  = w_win_d ? d_addr  : i_addr;
                    m_wdata_d = w_win_d ? d_wdata : i_wdata;
                    m_read_d  = !w_we_sel;
                    m_write_d = w_we_sel;
                    cnt_d     = C_CNT_LOAD;
                    busy_d    = 1'b1;
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    // Memory data is valid in the last strobe cycle only.
                    if (m_read_q) begin
                        if (grant_d_q) d_rdata_d = m_rdata;
                        else           i_rdata_d = m_rdata;
                    end
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                    i_ack_d   = !grant_d_q;
                    d_ack_d   = grant_d_q;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                m_read_d  = 1'b0;
                m_write_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            busy_q    <= 1'b0;
            grant_d_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            m_read_q  <= m_read_d;
            m_write_q <= m_write_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            busy_q    <= busy_d;
            grant_d_q <= grant_d_d;
        end
    end

    assign m_read  = m_read_q;
    assign m_write = m_write_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign busy    = busy_q;
    assign grant_d = grant_d_q;

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the CPU's instruction-fetch port and data port.
- Sits between the cpu top (i_readM/i_writeM/i_address and d_readM/d_writeM/d_address interfaces) and the memory model.
- Serialises requests, applies data-priority arbitration with an instruction anti-starvation guard, and returns an ack pulse plus read data to the winning requester.

Parameters:
- WORD_SIZE, 16, address and data width.
- MEM_LATENCY, 2, cycles m_read/m_write is held per access; legal range ≥1.
- MAX_D_STREAK, 4, maximum consecutive data grants while an instruction request waits; legal range ≥1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  instruction-port request, level; held until i_ack.
- i_we  in  1  1 = write, 0 = read; stable while i_req is high.
- i_addr  in  WORD_SIZE  instruction-port address.
- i_wdata  in  WORD_SIZE  instruction-port write data.
- i_rdata  out  WORD_SIZE  instruction-port read data, valid while i_ack is high.
- i_ack  out  1  one-cycle completion pulse for the instruction port.
- d_req, d_we, d_addr, d_wdata, d_rdata, d_ack: identical semantics for the data port.
- m_read  out  1  memory read strobe.
- m_write  out  1  memory write strobe.
- m_addr  out  WORD_SIZE  memory address.
- m_wdata  out  WORD_SIZE  memory write data.
- m_rdata  in  WORD_SIZE  memory read data; valid in the last strobe cycle.
- busy  out  1  high when state ≠ IDLE.
- grant_d  out  1  source of the current or last access (1 = data port).

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; m_read, m_write, i_ack, d_ack, busy, grant_d all 0; m_addr, m_wdata, i_rdata, d_rdata all 0; streak counter 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Sample i_req and d_req. If neither is high, stay in IDLE.
  - Otherwise select a winner:
    - Only one request high → that port wins.
    - Both high → data wins, unless streak == MAX_D_STREAK, in which case instruction wins.
  - Latch the winner's addr, wdata and we into m_addr, m_wdata and strobe select; set grant_d; load the latency counter with MEM_LATENCY-1; go to ACCESS.
- ACCESS:
  - m_read (we=0) or m_write (we=1) is high; m_addr and m_wdata are stable throughout.
  - Counter decrements each cycle. When the counter is 0: a read captures m_rdata into the winner's rdata register; go to RESP; strobes drop at the next edge.
- RESP:
  - Winner's ack = 1 for exactly one cycle. Read data is valid; on a write, rdata holds its previous value.
  - Requests are ignored in this state. Next state is IDLE.
- Timing: request sampled in IDLE at cycle T → strobe high in cycles T+1..T+MEM_LATENCY → ack in cycle T+MEM_LATENCY+1 → back in IDLE at T+MEM_LATENCY+2.
- Requester handshake:
  - The requester deasserts req at the edge ending its ack cycle.
  - A req still high in the following IDLE cycle is a new request.
  - Changing req, we, addr or wdata between request and ack is illegal; the arbiter's behaviour is then undefined, and the bench asserts against it.
- i_ack and d_ack are never high in the same cycle. m_read and m_write are never high together.
- Streak counter, updated on each grant:
  - Data grant while i_req is high → streak+1, saturating at MAX_D_STREAK.
  - Data grant while i_req is low → 0.
  - Any instruction grant → 0.
- m_addr and m_wdata hold their last values outside ACCESS. They are meaningful only while a strobe is high.
- Reset during ACCESS or RESP: the next cycle is IDLE with all strobes and acks 0. The in-flight access is abandoned without an ack; the requester must re-request.

Decomposition:
- Put state encodings (IDLE/ACCESS/RESP) and the grant-source constants in a shared header "mem_arb_defs.v", included the same way opcodes.v is.
- Sub-module arb_select: winner selection from i_req, d_req and streak, plus the saturating streak counter with its update rule.
- The top level keeps the FSM, latency counter and output registers.

Test Plan:
- Instruction read: mem[0x0010]=0xABCD, MEM_LATENCY=2, i_req at T → m_read=1 with m_addr=0x0010 in T+1..T+2; i_ack=1 and i_rdata=0xABCD at T+3; d_ack stays 0.
- Data write then read: d_we=1, addr 0x0200, wdata 0x1234 → m_write high for 2 cycles, d_ack at T+3. A following data read of 0x0200 → d_rdata=0x1234.
- Contention: i_req and d_req (reads) both high at T → data served first with d_ack at T+3, grant_d=1. The instruction request is sampled at T+4, i_ack at T+7, grant_d=0.
- Starvation guard: MAX_D_STREAK=4; d_req re-asserted immediately after each ack, i_req held high → exactly 4 d_acks, then i_ack, then streak=0 and data wins again.
- Reset mid-access: reset=1 at T+1 of a d read → at T+2 m_read=0, busy=0, and no d_ack ever appears for that access. A new request after reset completes normally.
- Parameter sweep: MEM_LATENCY=1 → strobe for a single cycle at T+1, ack at T+2. MEM_LATENCY=5 → ack at T+6.
